// File: rtl/seven_segment_decoder_if.sv
// Handshake bundle for the seven-segment decoder: a segment word in, a binary value out.
// The master drives words and takes results; the slave is the decoder.
interface seven_segment_decoder_if #(
  parameter int NUM_DIGITS = 4,
  parameter int OUT_WIDTH  = 16,
  parameter int ERR_W      = 2
);
  logic                    in_valid;
  logic                    in_ready;
  logic [NUM_DIGITS*7-1:0] seg_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [OUT_WIDTH-1:0]    value;
  logic                    error;
  logic [ERR_W-1:0]        err_digit;

  modport master (
    output in_valid, seg_in, out_ready,
    input  in_ready, out_valid, value, error, err_digit
  );

  modport slave (
    input  in_valid, seg_in, out_ready,
    output in_ready, out_valid, value, error, err_digit
  );
endinterface

// File: rtl/seven_segment_decoder.sv
// Recovers a binary value from a word of seven-segment digit patterns,
// one digit per cycle from the most significant, with valid/ready on both sides.
module seven_segment_decoder #(
  parameter int NUM_DIGITS = 4,
  parameter int OUT_WIDTH  = 16,
  parameter int ACTIVE_LOW = 1,
  parameter int ERR_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  seven_segment_decoder_if.slave bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  generate
    if (!((pow10(NUM_DIGITS) - 1) < (64'd1 << OUT_WIDTH))) begin : g_bad_out_width
      $error("OUT_WIDTH too narrow for NUM_DIGITS decimal digits");
    end
    if (ERR_W < $clog2(NUM_DIGITS)) begin : g_bad_err_w
      $error("ERR_W too narrow to index NUM_DIGITS digits");
    end
  endgenerate

  typedef enum logic [1:0] {ST_IDLE, ST_DECODE, ST_DONE} state_t;

  state_t                  state_q, state_d;
  logic [NUM_DIGITS*7-1:0] word_q, word_d;
  logic [OUT_WIDTH-1:0]    acc_q, acc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    seen_q, seen_d;
  logic                    err_q, err_d;
  logic [ERR_W-1:0]        err_digit_q, err_digit_d;

  // Normalise every digit to active-low so one decode table serves both polarities.
  logic [6:0] digit_pat [NUM_DIGITS];
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digit_pat[gi] = (ACTIVE_LOW != 0) ? word_q[7*gi +: 7] : ~word_q[7*gi +: 7];
    end
  endgenerate

  logic [6:0] cur_pat;
  logic [3:0] cur_val;
  logic       cur_legal;
  logic       cur_blank;
  logic       digit_bad;

  always_comb begin
    cur_pat   = digit_pat[idx_q];
    cur_val   = 4'd0;
    cur_legal = 1'b1;
    cur_blank = 1'b0;
    case (cur_pat)
      7'b1000000: cur_val = 4'd0;
      7'b1111001: cur_val = 4'd1;
      7'b0100100: cur_val = 4'd2;
      7'b0110000: cur_val = 4'd3;
      7'b0011001: cur_val = 4'd4;
      7'b0010010: cur_val = 4'd5;
      7'b0000010: cur_val = 4'd6;
      7'b1111000: cur_val = 4'd7;
      7'b0000000: cur_val = 4'd8;
      7'b0010000: cur_val = 4'd9;
      7'b1111111: cur_blank = 1'b1;
      default:    cur_legal = 1'b0;
    endcase
    // A blank is only a leading zero; once a digit has been seen it is illegal.
    digit_bad = !cur_legal || (cur_blank && seen_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      word_q      <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      seen_q      <= 1'b0;
      err_q       <= 1'b0;
      err_digit_q <= '0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      seen_q      <= seen_d;
      err_q       <= err_d;
      err_digit_q <= err_digit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus.in_valid) state_d = ST_DECODE;
      ST_DECODE: if (idx_q == '0) state_d = ST_DONE;
      ST_DONE:   if (bus.out_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    word_d      = word_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    seen_d      = seen_q;
    err_d       = err_q;
    err_digit_d = err_digit_q;
    if (state_q == ST_IDLE && bus.in_valid) begin
      word_d      = bus.seg_in;
      acc_d       = '0;
      idx_d       = IDX_W'(NUM_DIGITS - 1);
      seen_d      = 1'b0;
      err_d       = 1'b0;
      err_digit_d = '0;
    end else if (state_q == ST_DECODE) begin
      acc_d = acc_q * OUT_WIDTH'(10) + OUT_WIDTH'(cur_val);
      if (cur_legal && !cur_blank) seen_d = 1'b1;
      if (digit_bad) begin
        err_d = 1'b1;
        if (!err_q) err_digit_d = ERR_W'(idx_q);
      end
      if (idx_q != '0) idx_d = idx_q - 1'b1;
    end
  end

  always_comb begin
    bus.in_ready  = (state_q == ST_IDLE) && !rst;
    bus.out_valid = (state_q == ST_DONE);
    bus.value     = (state_q == ST_DONE && !err_q) ? acc_q : '0;
    bus.error     = (state_q == ST_DONE) && err_q;
    bus.err_digit = (state_q == ST_DONE) ? err_digit_q : '0;
  end

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Randomised and directed checks of the seven-segment decoder against a
// digit-table reference model.
module tb_seven_segment_decoder;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  seven_segment_decoder_if #(.NUM_DIGITS(4), .OUT_WIDTH(16), .ERR_W(2)) bus ();

  seven_segment_decoder #(
    .NUM_DIGITS(4), .OUT_WIDTH(16), .ACTIVE_LOW(1), .ERR_W(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] pat [11] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
                           7'b1111111};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] word4(input int d3, input int d2, input int d1, input int d0);
    return {pat[d3], pat[d2], pat[d1], pat[d0]};
  endfunction

  // Reference: a digit is its index in the table; leading blanks are skipped,
  // any other non-table pattern (including a later blank) is an error.
  function automatic void ref_decode(input logic [27:0] w, output int v, output int e, output int ed);
    int started;
    v = 0; e = 0; ed = 0; started = 0;
    for (int i = 3; i >= 0; i--) begin
      logic [6:0] p;
      int d;
      p = w[7*i +: 7];
      d = -1;
      for (int k = 0; k < 10; k++) if (pat[k] == p) d = k;
      if (d >= 0) begin
        started = 1;
        v += d * (10 ** i);
      end else if (!(p == 7'h7f && started == 0)) begin
        if (e == 0) begin e = 1; ed = i; end
      end
    end
    if (e != 0) v = 0;
  endfunction

  task automatic do_word(input logic [27:0] w, input int stall, input string tag);
    int ev, ee, ed, lat;
    ref_decode(w, ev, ee, ed);
    lat = 0;
    while (!bus.in_ready && lat < 20) begin @(negedge clk); lat++; end
    check({tag, "_in_ready"}, bus.in_ready, 1);
    bus.seg_in    = w;
    bus.in_valid  = 1'b1;
    bus.out_ready = (stall == 0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.seg_in   = 28'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin @(negedge clk); lat++; end
    check({tag, "_latency"}, lat, 4);
    check({tag, "_busy"}, bus.in_ready, 0);
    check({tag, "_value"}, bus.value, ev);
    check({tag, "_error"}, bus.error, ee);
    check({tag, "_err_digit"}, bus.err_digit, ed);
    for (int s = 0; s < stall; s++) begin
      bus.in_valid = 1'($urandom);
      bus.seg_in   = 28'($urandom);
      @(negedge clk);
      check({tag, "_hold_valid"}, bus.out_valid, 1);
      check({tag, "_hold_value"}, bus.value, ev);
      check({tag, "_hold_error"}, bus.error, ee);
      check({tag, "_hold_ready"}, bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_post_valid"}, bus.out_valid, 0);
    check({tag, "_post_ready"}, bus.in_ready, 1);
    $display("word %s seg=%h exp_value=%0d exp_err=%0d exp_digit=%0d", tag, w, ev, ee, ed);
  endtask

  initial begin
    int lat;
    logic [27:0] w;
    total = 0;
    bad   = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.seg_in    = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_value", bus.value, 0);
    check("rst_error", bus.error, 0);
    check("rst_err_digit", bus.err_digit, 0);
    rst = 1'b0;
    #1;
    check("rst_release_ready", bus.in_ready, 1);
    @(negedge clk);

    do_word(word4(1, 2, 3, 4), 0, "t1234");
    do_word(word4(10, 10, 4, 2), 0, "t42");
    do_word(word4(10, 10, 10, 10), 0, "tblank");
    do_word(word4(9, 9, 9, 9), 0, "t9999");
    do_word({pat[7], pat[7], 7'b1111110, pat[7]}, 0, "tbad1");
    do_word({7'b1010101, pat[1], pat[2], 7'b0000001}, 0, "tbad30");
    do_word(word4(1, 10, 2, 3), 0, "tembed");
    do_word(word4(5, 6, 7, 8), 10, "tstall");
    do_word(word4(8, 0, 6, 1), 0, "tafter");

    // Reset in the middle of decoding discards the word.
    bus.seg_in   = word4(3, 3, 3, 3);
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_value", bus.value, 0);
    check("mid_rst_ready", bus.in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_release_ready", bus.in_ready, 1);
    lat = 0;
    repeat (6) begin @(negedge clk); if (bus.out_valid) lat++; end
    check("mid_rst_discarded", lat, 0);
    do_word(word4(0, 5, 0, 0), 0, "t0500");

    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 4; i++) begin
        int r;
        r = $urandom_range(0, 19);
        if (r < 10)      w[7*i +: 7] = pat[r];
        else if (r < 15) w[7*i +: 7] = 7'h7f;
        else             w[7*i +: 7] = 7'($urandom);
      end
      do_word(w, $urandom_range(0, 3), $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end
endmodule
